// File: rtl/ddr2_traffic_gen_if.sv
// Local-side bus between the DDR2 traffic generator and the memory controller.
//
// Handshake: a request (write_req or read_req, never both) is presented with
// address and write data and is accepted in any cycle where the strobe and
// local_ready are both high at the rising clock edge. While the strobe is
// high and local_ready is low, address and write data are held stable.
// local_rdata is meaningful only in cycles where local_rdata_valid is high;
// read data returns in request order.
interface ddr2_traffic_gen_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 64
);
  logic              local_init_done;
  logic              local_ready;
  logic [DATA_W-1:0] local_rdata;
  logic              local_rdata_valid;
  logic [ADDR_W-1:0] local_address;
  logic              local_write_req;
  logic              local_read_req;
  logic [DATA_W-1:0] local_wdata;

  modport master (
    input  local_init_done, local_ready, local_rdata, local_rdata_valid,
    output local_address, local_write_req, local_read_req, local_wdata
  );

  modport slave (
    output local_init_done, local_ready, local_rdata, local_rdata_valid,
    input  local_address, local_write_req, local_read_req, local_wdata
  );
endinterface

// File: rtl/ddr2_traffic_gen.sv
// DDR2 traffic generator: writes a pattern over an address range, reads it
// back, compares against an independently regenerated pattern and reports
// status. Supports repeated passes in continuous mode.
module ddr2_traffic_gen #(
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 64,
  parameter int WORDS     = 256,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_STEP = 1,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  input  logic [1:0]        mode,
  ddr2_traffic_gen_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout_err,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [15:0]       pass_cnt,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_INIT = 3'd1,
    S_WRITE     = 3'd2,
    S_READ      = 3'd3,
    S_DRAIN     = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);
  localparam logic [15:0]       LAST_IDX = 16'(WORDS - 1);
  localparam logic [16:0]       NWORDS   = 17'(WORDS);
  localparam logic [31:0]       IDLE_MAX = 32'(TIMEOUT - 1);
  localparam logic [31:0]       LFSR_MASK = 32'h8020_0003;  // taps 32,22,2,1

  // Galois LFSR, shifting right; feedback from bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ LFSR_MASK;
    return n;
  endfunction

  // Data pattern for word index idx; lf is the LFSR state for that word.
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m,
                                                input logic [15:0] idx,
                                                input logic [31:0] lf);
    logic [DATA_W-1:0] p;
    logic [15:0]       bitpos;
    p = '0;
    bitpos = idx % 16'(DATA_W);
    case (m)
      2'd0: p = DATA_W'(idx);
      2'd1: p = ~DATA_W'(idx);
      2'd2: p = {{(DATA_W-1){1'b0}}, 1'b1} << bitpos;
      default: p = {(DATA_W/32){lf}};
    endcase
    return p;
  endfunction

  state_t            state, state_nx;
  logic [1:0]        mode_q;
  logic              stop_q;
  logic              gap_q;
  logic [15:0]       idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       lfsr_w;
  logic [16:0]       r_cnt;
  logic [ADDR_W-1:0] raddr_q;
  logic [31:0]       lfsr_r;
  logic [31:0]       idle_cnt;
  logic [15:0]       err_q;
  logic [ADDR_W-1:0] first_err_q;
  logic [15:0]       pass_q;
  logic              timeout_q;

  logic wr_on, rd_on, accept, last_issue;
  logic rx_ok, mismatch, rx_done;
  logic load_w, load_r, pass_end, run_start, to_timeout;

  // Request strobes, acceptance and checker qualifiers.
  always_comb begin
    wr_on      = (state == S_WRITE);
    rd_on      = (state == S_READ) && !gap_q;
    accept     = (wr_on || rd_on) && bus.local_ready;
    last_issue = (idx_q == LAST_IDX);
    rx_ok      = bus.local_rdata_valid && (r_cnt < NWORDS) &&
                 ((state == S_READ) || (state == S_DRAIN));
    mismatch   = rx_ok && (bus.local_rdata != pattern(mode_q, r_cnt[15:0], lfsr_r));
    rx_done    = (r_cnt == NWORDS);
  end

  // Next-state logic and per-transition control strobes.
  always_comb begin
    state_nx   = state;
    load_w     = 1'b0;
    load_r     = 1'b0;
    pass_end   = 1'b0;
    run_start  = 1'b0;
    to_timeout = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx  = S_WAIT_INIT;
          run_start = 1'b1;
        end
      end
      S_WAIT_INIT: begin
        if (bus.local_init_done) begin
          state_nx = S_WRITE;
          load_w   = 1'b1;
        end
      end
      S_WRITE: begin
        if (!bus.local_init_done) begin
          state_nx = S_WAIT_INIT;
        end else if (accept && last_issue) begin
          state_nx = S_READ;
          load_r   = 1'b1;
        end
      end
      S_READ: begin
        if (!bus.local_init_done) begin
          state_nx = S_WAIT_INIT;
        end else if (accept && last_issue) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!bus.local_init_done) begin
          state_nx = S_WAIT_INIT;
        end else if (rx_done) begin
          pass_end = 1'b1;
          if (continuous && !stop_q && !stop) begin
            state_nx = S_WRITE;
            load_w   = 1'b1;
          end else begin
            state_nx = S_DONE;
          end
        end else if ((idle_cnt == IDLE_MAX) && !bus.local_rdata_valid) begin
          state_nx   = S_DONE;
          to_timeout = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, issue side, checker side and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mode_q      <= 2'd0;
      stop_q      <= 1'b0;
      gap_q       <= 1'b0;
      idx_q       <= 16'd0;
      addr_q      <= '0;
      lfsr_w      <= 32'd0;
      r_cnt       <= 17'd0;
      raddr_q     <= '0;
      lfsr_r      <= 32'd0;
      idle_cnt    <= 32'd0;
      err_q       <= 16'd0;
      first_err_q <= '0;
      pass_q      <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      state <= state_nx;
      gap_q <= load_r;

      if (run_start) begin
        mode_q      <= mode;
        err_q       <= 16'd0;
        first_err_q <= '0;
        pass_q      <= 16'd0;
        timeout_q   <= 1'b0;
      end

      // A stop request is remembered until the pass it arrived in ends.
      if (run_start || pass_end) stop_q <= 1'b0;
      else if (busy && stop)     stop_q <= 1'b1;

      if (load_w || load_r) begin
        idx_q  <= 16'd0;
        addr_q <= BASE;
        lfsr_w <= LFSR_SEED;
      end else if (accept) begin
        idx_q  <= idx_q + 16'd1;
        addr_q <= addr_q + STEP;
        lfsr_w <= lfsr_next(lfsr_w);
      end

      if (load_w || load_r) begin
        r_cnt   <= 17'd0;
        raddr_q <= BASE;
        lfsr_r  <= LFSR_SEED;
      end else if (rx_ok) begin
        r_cnt   <= r_cnt + 17'd1;
        raddr_q <= raddr_q + STEP;
        lfsr_r  <= lfsr_next(lfsr_r);
      end

      if (mismatch) begin
        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
        if (err_q == 16'd0)    first_err_q <= raddr_q;
      end

      if (pass_end)   pass_q    <= pass_q + 16'd1;
      if (to_timeout) timeout_q <= 1'b1;

      if ((state == S_DRAIN) && !bus.local_rdata_valid) idle_cnt <= idle_cnt + 32'd1;
      else                                               idle_cnt <= 32'd0;
    end
  end

  // Outputs; bus fields read as zero whenever no request phase is active.
  always_comb begin
    bus.local_write_req = wr_on;
    bus.local_read_req  = rd_on;
    bus.local_address   = (wr_on || state == S_READ) ? addr_q : '0;
    bus.local_wdata     = wr_on ? pattern(mode_q, idx_q, lfsr_w) : '0;
    busy           = (state == S_WAIT_INIT) || (state == S_WRITE) ||
                     (state == S_READ) || (state == S_DRAIN);
    done           = (state == S_DONE);
    pass           = (state == S_DONE) && (err_q == 16'd0) && !timeout_q;
    timeout_err    = timeout_q;
    err_cnt        = err_q;
    first_err_addr = first_err_q;
    pass_cnt       = pass_q;
    state_dbg      = state;
  end

endmodule

// File: doc/ddr2_traffic_gen.md
DDR2_TRAFFIC_GEN -- requirements
Module: ddr2_traffic_gen

Interface
REQ-001 Parameter ADDR_W, default 23, local address width.
REQ-002 Parameter DATA_W, default 64, local data width; SHALL be a multiple of 32.
REQ-003 Parameter WORDS, default 256, words per write/read pass (2..65535).
REQ-004 Parameter BASE_ADDR, default 0, first address of each pass.
REQ-005 Parameter ADDR_STEP, default 1, address increment per word.
REQ-006 Parameter LFSR_SEED, default 32'hACE1_0001, nonzero LFSR seed.
REQ-007 Parameter TIMEOUT, default 4096, max idle cycles waiting for read data.
REQ-008 clk  in  1  single clock (phy_clk domain); one clock; reset is synchronous and active-high.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 start  in  1  one-cycle pulse, begins a test run.
REQ-011 continuous  in  1  when high, runs repeat passes until stop.
REQ-012 stop  in  1  ends continuous run after current pass.
REQ-013 mode  in  2  pattern select, sampled on accepted start.
REQ-014 local_init_done  in  1  controller calibration complete.
REQ-015 local_ready  in  1  controller accepts current request.
REQ-016 local_rdata  in  DATA_W  read data.
REQ-017 local_rdata_valid  in  1  read data qualifier.
REQ-018 local_address  out  ADDR_W  request address.
REQ-019 local_write_req / local_read_req  out  1 each  request strobes.
REQ-020 local_wdata  out  DATA_W  write data.
REQ-021 busy, done, pass, timeout_err  out  1 each  status.
REQ-022 err_cnt  out  16  saturating mismatch count; first_err_addr  out  ADDR_W.
REQ-023 pass_cnt  out  16  completed passes, wraps.

Function
REQ-024 States: IDLE, WAIT_INIT, WRITE, READ, DRAIN, DONE; reset enters IDLE.
REQ-025 IDLE: start -> WAIT_INIT, clears err_cnt, timeout_err, first_err_addr, pass_cnt, done; start ignored when not IDLE/DONE.
REQ-026 WAIT_INIT: local_init_done high -> WRITE next cycle.
REQ-027 Issue index i runs 0..WORDS-1; local_address = BASE_ADDR + i*ADDR_STEP modulo 2^ADDR_W.
REQ-028 Request accepted in the cycle req && local_ready; i advances and address/data update next cycle; req held with stable address/data while ready low.
REQ-029 WRITE: local_write_req high; after acceptance of i=WORDS-1 -> READ with i=0, req low for exactly one cycle between phases.
REQ-030 READ: local_read_req high; after acceptance of i=WORDS-1 -> DRAIN.
REQ-031 Never both write_req and read_req high.
REQ-032 Pattern per word i: mode0 i zero-extended; mode1 bitwise inverse of mode0; mode2 single 1 at bit (i mod DATA_W); mode3 32-bit Galois LFSR (taps 32,22,2,1) replicated DATA_W/32 times, seeded LFSR_SEED at phase start, stepped once per word.
REQ-033 Checker holds separate receive index r (0..WORDS-1) and own pattern generator; each local_rdata_valid in READ/DRAIN compares local_rdata to pattern(r), then r increments.
REQ-034 Mismatch: err_cnt increments, saturates at 16'hFFFF; first_err_addr captures address of r on first mismatch of run only.
REQ-035 local_rdata_valid outside READ/DRAIN ignored.
REQ-036 Read data may arrive while still issuing; received-word count never exceeds WORDS; extra valids ignored.
REQ-037 DRAIN: r reaches WORDS -> pass_cnt+1; then continuous && !stop -> WRITE (new pass, i=0, r=0), else DONE.
REQ-038 DRAIN timeout: TIMEOUT consecutive cycles without valid -> timeout_err=1, DONE.
REQ-039 stop sampled any cycle during run and held internally until pass end.
REQ-040 DONE: done=1, pass=(err_cnt==0 && !timeout_err); held until next start.
REQ-041 busy=1 in WAIT_INIT..DRAIN.
REQ-042 local_init_done falling mid-run: abort to WAIT_INIT, restart pass at i=0, counters kept.

Reset
REQ-043 rst forces IDLE; all outputs 0 (local_address=0, local_wdata=0, counters 0) next edge, including mid-transaction.

Verification
REQ-044 WORDS=8, mode0, ideal memory model, ready always 1 -> 8 writes data 0..7, 8 reads, done=1, pass=1, err_cnt=0, pass_cnt=1.
REQ-045 ready toggling 1-of-3 cycles -> address/data stable while req high and ready low; result identical to REQ-044.
REQ-046 Model corrupts word 5 bit 0, mode3 -> err_cnt=1, first_err_addr=BASE_ADDR+5*ADDR_STEP, pass=0.
REQ-047 Model drops last read data, TIMEOUT=16 -> timeout_err=1 after 16 idle cycles, done=1, pass=0.
REQ-048 continuous=1, stop pulse during pass 3 -> pass_cnt=3, then DONE; BASE_ADDR near 2^ADDR_W-1 -> addresses wrap to 0.
REQ-049 rst asserted during READ -> all outputs 0 next cycle, IDLE, fresh start runs clean.
